// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared types and helpers for the iterative RV32M
//               multiply/divide unit: operand width, funct3 operation
//               encoding, FSM state encoding and a two's-complement negate.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    localparam int XLEN = 32;

    // RV32M funct3 encoding
    typedef enum logic [2:0] {
        F3_MUL    = 3'd0,
        F3_MULH   = 3'd1,
        F3_MULHSU = 3'd2,
        F3_MULHU  = 3'd3,
        F3_DIV    = 3'd4,
        F3_DIVU   = 3'd5,
        F3_REM    = 3'd6,
        F3_REMU   = 3'd7
    } funct3_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Two's-complement negate of an XLEN-bit value
    function automatic logic [XLEN-1:0] neg32(input logic [XLEN-1:0] v);
        return ~v + {{(XLEN-1){1'b0}}, 1'b1};
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative RV32M multiply/divide execution unit. Shift-add
//               multiply and restoring divide, one result bit per clock.
//               Divide-by-zero and signed-overflow cases bypass iteration.
//               The register-file write port is registered: the result held
//               in DONE is written out on the edge that returns to IDLE.
// Ports       : clk, reset (async, active-high)
//               in_valid/in_ready  - request handshake (ready only in IDLE)
//               funct3, op_a, op_b, rd - operation, sources, destination
//               flush              - abort in-flight op, no writeback
//               busy               - unit not idle
//               we_out/wa_out/wd_out - register file write port
// Config      : MULDIV_EARLY_OUT_EN - when defined, multiplies leave CALC as
//               soon as the remaining multiplier bits are all zero.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd,
    input  logic            flush,
    output logic            busy,
    output logic            we_out,
    output logic [4:0]      wa_out,
    output logic [XLEN-1:0] wd_out
);
    import muldiv_pkg::*;

    localparam logic [CNT_W-1:0] c_last_iter = CNT_W'(XLEN - 1);
    localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e            r_state_q,  w_state_d;
    logic [CNT_W-1:0]  r_cnt_q,    w_cnt_d;
    funct3_e           r_op_q,     w_op_d;
    logic [4:0]        r_rd_q,     w_rd_d;
    logic              r_neg_q,    w_neg_d;     // result needs negation
    logic [2*XLEN-1:0] r_acc_q,    w_acc_d;     // multiply accumulator
    logic [XLEN:0]     r_rem_q,    w_rem_d;     // divide partial remainder
    logic [XLEN-1:0]   r_mcand_q,  w_mcand_d;   // multiplicand or divisor
    logic [XLEN-1:0]   r_mplier_q, w_mplier_d;  // multiplier or dividend/quotient
    logic [XLEN-1:0]   r_result_q, w_result_d;
    logic              r_we_q,     w_we_d;
    logic [4:0]        r_wa_q,     w_wa_d;
    logic [XLEN-1:0]   r_wd_q,     w_wd_d;

    // ------------------------------------------------------------------
    // Request decode (evaluated on the accept edge)
    // ------------------------------------------------------------------
    funct3_e         w_in_op;
    logic            w_a_signed, w_b_signed;
    logic            w_sa, w_sb;
    logic [XLEN-1:0] w_mag_a, w_mag_b;
    logic            w_in_neg;
    logic            w_b_zero, w_ovf, w_fast;
    logic [XLEN-1:0] w_fast_result;

    assign w_in_op    = funct3_e'(funct3);
    assign w_a_signed = (w_in_op == F3_MULH) || (w_in_op == F3_MULHSU) ||
                        (w_in_op == F3_DIV)  || (w_in_op == F3_REM);
    assign w_b_signed = (w_in_op == F3_MULH) || (w_in_op == F3_DIV) ||
                        (w_in_op == F3_REM);
    assign w_sa       = w_a_signed & op_a[XLEN-1];
    assign w_sb       = w_b_signed & op_b[XLEN-1];
    assign w_mag_a    = w_sa ? neg32(op_a) : op_a;
    assign w_mag_b    = w_sb ? neg32(op_b) : op_b;
    // Remainder follows the dividend's sign; everything else is sa^sb.
    assign w_in_neg   = (w_in_op == F3_REM) ? w_sa : (w_sa ^ w_sb);

    assign w_b_zero = (op_b == '0);
    assign w_ovf    = (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (&op_b) &&
                      ((w_in_op == F3_DIV) || (w_in_op == F3_REM));
    assign w_fast   = funct3[2] && (w_b_zero || w_ovf);

    // funct3[1] distinguishes remainder from quotient among divides
    always_comb begin
        w_fast_result = '0;
        if (w_b_zero) begin
            w_fast_result = funct3[1] ? op_a : '1;
        end else begin
            w_fast_result = funct3[1] ? '0 : op_a;
        end
    end

    // ------------------------------------------------------------------
    // Multiply step: add multiplicand into the upper half when the
    // multiplier LSB is set, then shift the 65-bit sum right by one.
    // ------------------------------------------------------------------
    logic [XLEN:0]     w_mul_sum;
    logic [2*XLEN:0]   w_acc_wide;
    logic [2*XLEN-1:0] w_acc_step;
    logic [XLEN-1:0]   w_mplier_shr;
    logic              w_mul_last;
    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_prod_signed;
    logic [XLEN-1:0]   w_mul_result;

    assign w_mul_sum    = {1'b0, r_acc_q[2*XLEN-1:XLEN]} +
                          (r_mplier_q[0] ? {1'b0, r_mcand_q} : '0);
    assign w_acc_wide   = {w_mul_sum, r_acc_q[XLEN-1:0]};
    assign w_acc_step   = (2*XLEN)'(w_acc_wide >> 1);
    assign w_mplier_shr = r_mplier_q >> 1;

`ifdef MULDIV_EARLY_OUT_EN
    // Once no multiplier bits remain, the outstanding iterations would only
    // shift; apply that shift in one go.
    assign w_mul_last = (r_cnt_q == c_last_iter) || (w_mplier_shr == '0);
    assign w_prod     = w_acc_step >> (c_last_iter - r_cnt_q);
`else
    assign w_mul_last = (r_cnt_q == c_last_iter);
    assign w_prod     = w_acc_step;
`endif

    assign w_prod_signed = r_neg_q ? (~w_prod + {{(2*XLEN-1){1'b0}}, 1'b1}) : w_prod;
    assign w_mul_result  = (r_op_q == F3_MUL) ? w_prod_signed[XLEN-1:0]
                                              : w_prod_signed[2*XLEN-1:XLEN];

    // ------------------------------------------------------------------
    // Divide step: shift the next dividend bit into the partial remainder,
    // trial-subtract the divisor, keep the difference when no borrow.
    // ------------------------------------------------------------------
    logic [XLEN+1:0] w_div_shift;
    logic [XLEN+1:0] w_div_diff;
    logic            w_qbit;
    logic [XLEN:0]   w_rem_step;
    logic [XLEN-1:0] w_quo_step;
    logic [XLEN-1:0] w_div_result;

    assign w_div_shift = {r_rem_q, r_mplier_q[XLEN-1]};
    assign w_div_diff  = w_div_shift - {2'b00, r_mcand_q};
    assign w_qbit      = ~w_div_diff[XLEN+1];
    assign w_rem_step  = w_qbit ? w_div_diff[XLEN:0] : w_div_shift[XLEN:0];
    assign w_quo_step  = {r_mplier_q[XLEN-2:0], w_qbit};

    always_comb begin
        w_div_result = '0;
        if (r_op_q[1]) begin
            w_div_result = r_neg_q ? neg32(w_rem_step[XLEN-1:0]) : w_rem_step[XLEN-1:0];
        end else begin
            w_div_result = r_neg_q ? neg32(w_quo_step) : w_quo_step;
        end
    end

    // ------------------------------------------------------------------
    // Next-state / datapath control
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d  = r_state_q;
        w_cnt_d    = r_cnt_q;
        w_op_d     = r_op_q;
        w_rd_d     = r_rd_q;
        w_neg_d    = r_neg_q;
        w_acc_d    = r_acc_q;
        w_rem_d    = r_rem_q;
        w_mcand_d  = r_mcand_q;
        w_mplier_d = r_mplier_q;
        w_result_d = r_result_q;
        w_we_d     = 1'b0;
        w_wa_d     = r_wa_q;
        w_wd_d     = r_wd_q;

        case (r_state_q)
            S_IDLE: begin
                // flush in IDLE blocks the accept
                if (in_valid && !flush) begin
                    w_op_d  = w_in_op;
                    w_rd_d  = rd;
                    w_neg_d = w_in_neg;
                    w_cnt_d = '0;
                    w_acc_d = '0;
                    w_rem_d = '0;
                    if (w_fast) begin
                        w_result_d = w_fast_result;
                        w_state_d  = S_DONE;
                    end else begin
                        w_state_d = S_CALC;
                        if (funct3[2]) begin
                            w_mcand_d  = w_mag_b;
                            w_mplier_d = w_mag_a;
                        end else begin
                            w_mcand_d  = w_mag_a;
                            w_mplier_d = w_mag_b;
                        end
                    end
                end
            end

            S_CALC: begin
                if (flush) begin
                    w_state_d = S_IDLE;
                end else if (r_op_q[2]) begin
                    w_rem_d    = w_rem_step;
                    w_mplier_d = w_quo_step;
                    w_cnt_d    = r_cnt_q + c_cnt_one;
                    if (r_cnt_q == c_last_iter) begin
                        w_result_d = w_div_result;
                        w_state_d  = S_DONE;
                    end
                end else begin
                    w_acc_d    = w_acc_step;
                    w_mplier_d = w_mplier_shr;
                    w_cnt_d    = r_cnt_q + c_cnt_one;
                    if (w_mul_last) begin
                        w_result_d = w_mul_result;
                        w_state_d  = S_DONE;
                    end
                end
            end

            S_DONE: begin
                w_state_d = S_IDLE;
                if (!flush) begin
                    w_we_d = (r_rd_q != 5'd0);
                    w_wa_d = r_rd_q;
                    w_wd_d = r_result_q;
                end
            end

            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state_q  <= S_IDLE;
            r_cnt_q    <= '0;
            r_op_q     <= F3_MUL;
            r_rd_q     <= '0;
            r_neg_q    <= 1'b0;
            r_acc_q    <= '0;
            r_rem_q    <= '0;
            r_mcand_q  <= '0;
            r_mplier_q <= '0;
            r_result_q <= '0;
            r_we_q     <= 1'b0;
            r_wa_q     <= '0;
            r_wd_q     <= '0;
        end else begin
            r_state_q  <= w_state_d;
            r_cnt_q    <= w_cnt_d;
            r_op_q     <= w_op_d;
            r_rd_q     <= w_rd_d;
            r_neg_q    <= w_neg_d;
            r_acc_q    <= w_acc_d;
            r_rem_q    <= w_rem_d;
            r_mcand_q  <= w_mcand_d;
            r_mplier_q <= w_mplier_d;
            r_result_q <= w_result_d;
            r_we_q     <= w_we_d;
            r_wa_q     <= w_wa_d;
            r_wd_q     <= w_wd_d;
        end
    end

    assign in_ready = (r_state_q == S_IDLE);
    assign busy     = (r_state_q != S_IDLE);
    assign we_out   = r_we_q;
    assign wa_out   = r_wa_q;
    assign wd_out   = r_wd_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Self-checking bench for muldiv_unit. Directed RV32M vectors,
//               randomized operations against an arithmetic reference model,
//               flush, reset, rd==0 and held-request scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;
    logic [4:0]  rd = 5'd0;
    logic        flush = 1'b0;
    logic        busy;
    logic        we_out;
    logic [4:0]  wa_out;
    logic [31:0] wd_out;

    int checks = 0;
    int failures = 0;

    muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .funct3   (funct3),
        .op_a     (op_a),
        .op_b     (op_b),
        .rd       (rd),
        .flush    (flush),
        .busy     (busy),
        .we_out   (we_out),
        .wa_out   (wa_out),
        .wd_out   (wd_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] pv;
        int ia, ib;
        logic ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'({32'd0, a});
        ub  = longint'({32'd0, b});
        ia  = $signed(a);
        ib  = $signed(b);
        ovf = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
        case (f)
            3'd0: begin pv = ua * ub; return pv[31:0];  end
            3'd1: begin pv = sa * sb; return pv[63:32]; end
            3'd2: begin pv = sa * ub; return pv[63:32]; end
            3'd3: begin pv = ua * ub; return pv[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (ovf) return 32'h80000000;
                return 32'(ia / ib);
            end
            3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                return 32'(ia % ib);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Cycles from the accept edge to the cycle in which we_out is high.
    function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a,
                                   input logic [31:0] b);
        if (f[2]) begin
            if (b == 0) return 2;
            if ((f == 3'd4 || f == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 2;
            return 34;
        end
`ifdef MULDIV_EARLY_OUT_EN
        begin
            logic [31:0] m;
            int k;
            m = (f == 3'd1 && b[31]) ? (32'd0 - b) : b;
            k = 1;
            for (int i = 0; i < 32; i++) if (m[i]) k = i + 1;
            return k + 2;
        end
`else
        return 34;
`endif
    endfunction

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 5))
            0:       return 32'h00000000;
            1:       return 32'hFFFFFFFF;
            2:       return 32'h80000000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Issue one op and wait (bounded) for its write pulse.
    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] r, output logic got, output logic [31:0] res,
                         output logic [4:0] wa, output int lat, output int bcnt);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        funct3 = f; op_a = a; op_b = b; rd = r; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        got = 1'b0; lat = 0; bcnt = 0; res = '0; wa = '0;
        while (!got && lat < 60) begin
            @(negedge clk);
            lat++;
            if (busy) bcnt++;
            if (we_out) begin
                got = 1'b1;
                res = wd_out;
                wa  = wa_out;
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || we_out !== 1'b0 ||
            wa_out !== 5'd0 || wd_out !== 32'd0) begin
            failures++;
            $display("FAIL reset_state: ready=%b busy=%b we=%b wa=%0d wd=%h, want 1 0 0 0 0",
                     in_ready, busy, we_out, wa_out, wd_out);
        end
        reset = 1'b0;
    endtask

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  r;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [14] = '{
        '{3'd0, 32'd7,          32'd6,          5'd5,  32'd42},
        '{3'd1, 32'hFFFFFFFF,   32'd2,          5'd6,  32'hFFFFFFFF},
        '{3'd3, 32'hFFFFFFFF,   32'd2,          5'd7,  32'd1},
        '{3'd2, 32'hFFFFFFFF,   32'd2,          5'd8,  32'hFFFFFFFF},
        '{3'd4, 32'hFFFFFFF9,   32'd2,          5'd9,  32'hFFFFFFFD},
        '{3'd6, 32'hFFFFFFF9,   32'd2,          5'd10, 32'hFFFFFFFF},
        '{3'd5, 32'd100,        32'd7,          5'd11, 32'd14},
        '{3'd7, 32'd100,        32'd7,          5'd12, 32'd2},
        '{3'd4, 32'd5,          32'd0,          5'd13, 32'hFFFFFFFF},
        '{3'd6, 32'd5,          32'd0,          5'd14, 32'd5},
        '{3'd4, 32'h80000000,   32'hFFFFFFFF,   5'd15, 32'h80000000},
        '{3'd6, 32'h80000000,   32'hFFFFFFFF,   5'd16, 32'd0},
        '{3'd5, 32'd5,          32'd0,          5'd17, 32'hFFFFFFFF},
        '{3'd1, 32'h80000000,   32'h80000000,   5'd18, 32'h40000000}
    };

    task automatic test_directed();
        logic got;
        logic [31:0] res;
        logic [4:0] wa;
        int lat, bc, el;
        for (int i = 0; i < 14; i++) begin
            do_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].r, got, res, wa, lat, bc);
            el = exp_lat(vecs[i].f, vecs[i].a, vecs[i].b);
            checks++;
            if (!got || res !== vecs[i].exp) begin
                failures++;
                $display("FAIL directed_result[%0d]: got=%b wd=%h want %h", i, got, res, vecs[i].exp);
            end
            checks++;
            if (wa !== vecs[i].r) begin
                failures++;
                $display("FAIL directed_wa[%0d]: wa=%0d want %0d", i, wa, vecs[i].r);
            end
            checks++;
            if (lat != el || bc != el - 1) begin
                failures++;
                $display("FAIL directed_latency[%0d]: lat=%0d busy=%0d want %0d %0d",
                         i, lat, bc, el, el - 1);
            end
            @(negedge clk);
            checks++;
            if (we_out !== 1'b0 || wa_out !== vecs[i].r || wd_out !== vecs[i].exp) begin
                failures++;
                $display("FAIL directed_pulse_hold[%0d]: we=%b wa=%0d wd=%h want 0 %0d %h",
                         i, we_out, wa_out, wd_out, vecs[i].r, vecs[i].exp);
            end
        end
    endtask

    task automatic test_random();
        logic got;
        logic [31:0] res, a, b, e;
        logic [4:0] wa, r;
        logic [2:0] f;
        int lat, bc;
        for (int i = 0; i < 30; i++) begin
            f = 3'($urandom_range(0, 7));
            a = pick_val();
            b = pick_val();
            r = 5'($urandom_range(1, 31));
            e = ref_result(f, a, b);
            do_op(f, a, b, r, got, res, wa, lat, bc);
            checks++;
            if (!got || res !== e || wa !== r || lat != exp_lat(f, a, b)) begin
                failures++;
                $display("FAIL random[%0d] f=%0d a=%h b=%h: got=%b wd=%h wa=%0d lat=%0d want %h %0d %0d",
                         i, f, a, b, got, res, wa, lat, e, r, exp_lat(f, a, b));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic got;
        logic [31:0] res;
        logic [4:0] wa;
        int lat;
        @(negedge clk);
        funct3 = 3'd5; op_a = 32'd1000; op_b = 32'd7; rd = 5'd3; in_valid = 1'b1;
        @(posedge clk);
        #1 funct3 = 3'd4; op_a = 32'hFFFFFFCE; op_b = 32'd7; rd = 5'd4;
        got = 1'b0; lat = 0; res = '0; wa = '0;
        while (!got && lat < 60) begin
            @(negedge clk);
            lat++;
            if (we_out) begin got = 1'b1; res = wd_out; wa = wa_out; end
        end
        checks++;
        if (!got || res !== 32'd142 || wa !== 5'd3 || lat != 34) begin
            failures++;
            $display("FAIL b2b_first: got=%b wd=%h wa=%0d lat=%0d want 0000008e 3 34", got, res, wa, lat);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_ready: in_ready=%b want 1", in_ready);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        got = 1'b0; lat = 0;
        while (!got && lat < 60) begin
            @(negedge clk);
            lat++;
            if (we_out) begin got = 1'b1; res = wd_out; wa = wa_out; end
        end
        checks++;
        if (!got || res !== 32'hFFFFFFF9 || wa !== 5'd4 || lat != 34) begin
            failures++;
            $display("FAIL b2b_second: got=%b wd=%h wa=%0d lat=%0d want fffffff9 4 34", got, res, wa, lat);
        end
    endtask

    task automatic test_flush();
        bit seen;
        // flush 10 cycles into a divide
        @(negedge clk);
        funct3 = 3'd4; op_a = 32'd1000; op_b = 32'd3; rd = 5'd9; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_calc_idle: busy=%b ready=%b want 0 1", busy, in_ready);
        end
        seen = 1'b0;
        repeat (40) begin @(negedge clk); if (we_out) seen = 1'b1; end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL flush_calc_nowrite: we_out pulsed=1 want 0");
        end
        // flush while in DONE (fast-path op)
        @(negedge clk);
        funct3 = 3'd4; op_a = 32'd5; op_b = 32'd0; rd = 5'd20; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0; flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        seen = we_out;
        repeat (5) begin @(negedge clk); if (we_out) seen = 1'b1; end
        checks++;
        if (seen || busy !== 1'b0) begin
            failures++;
            $display("FAIL flush_done: we pulsed=%b busy=%b want 0 0", seen, busy);
        end
        // flush in IDLE blocks the accept
        @(negedge clk);
        funct3 = 3'd5; op_a = 32'd50; op_b = 32'd5; rd = 5'd21; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL flush_idle_accept: busy=%b want 0", busy);
        end
    endtask

    task automatic test_rd_zero();
        logic got;
        logic [31:0] res;
        logic [4:0] wa;
        int lat, bc;
        do_op(3'd0, 32'd3, 32'd3, 5'd0, got, res, wa, lat, bc);
        checks++;
        if (got !== 1'b0) begin
            failures++;
            $display("FAIL rd_zero_we: we_out seen=%b want 0", got);
        end
        checks++;
        if (bc != exp_lat(3'd0, 32'd3, 32'd3) - 1 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rd_zero_busy: busy cycles=%0d ready=%b want %0d 1",
                     bc, in_ready, exp_lat(3'd0, 32'd3, 32'd3) - 1);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        logic got;
        logic [31:0] res;
        logic [4:0] wa;
        int lat, bc;
        @(negedge clk);
        funct3 = 3'd0; op_a = 32'd123; op_b = 32'd456; rd = 5'd7; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (we_out !== 1'b0 || wa_out !== 5'd0 || wd_out !== 32'd0 ||
            busy !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid: we=%b wa=%0d wd=%h busy=%b ready=%b want 0 0 0 0 1",
                     we_out, wa_out, wd_out, busy, in_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        repeat (40) begin @(negedge clk); if (we_out) seen = 1'b1; end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL reset_mid_nowrite: we_out pulsed=1 want 0");
        end
        do_op(3'd0, 32'd123, 32'd456, 5'd7, got, res, wa, lat, bc);
        checks++;
        if (!got || res !== 32'd56088 || wa !== 5'd7) begin
            failures++;
            $display("FAIL reset_recover: got=%b wd=%h wa=%0d want 0000db18 7", got, res, wa);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_flush();
        test_rd_zero();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
